dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory slave with a fixed access latency and a
// valid/ready request and response handshake. Handles RISC-V byte, half and word loads and stores.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        write_q;
  logic [AW+1:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, enter_resp;
  logic          cur_write;
  logic [AW+1:0] cur_addr;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_idx;
  logic          illegal, misaligned, err;
  logic [3:0]    byte_en;
  logic [31:0]   store_data, word, shifted, load_val;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && (state == IDLE);

  // With zero wait cycles the access completes on the accept edge, so the
  // live request inputs are used before they have been latched.
  assign cur_write = (state == IDLE) ? req_write : write_q;
  assign cur_addr  = (state == IDLE) ? req_addr[AW+1:0] : addr_q;
  assign cur_f3    = (state == IDLE) ? req_f3 : f3_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign cur_idx   = cur_addr[AW+1:2];

  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (count <= 4'd1));

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
          count_next = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count <= 4'd1) state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if (cur_write) illegal = !(cur_f3 inside {3'b000, 3'b001, 3'b010});
    else           illegal = !(cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                 ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    err = illegal || misaligned;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << cur_addr[1:0];
        store_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en    = cur_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{cur_wdata[15:0]}};
      end
      2'b10: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    word    = mem[cur_idx];
    shifted = word >> {cur_addr[1:0], 3'b000};
    case (cur_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      f3_q       <= 3'b000;
      wdata_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr[AW+1:0];
        f3_q    <= req_f3;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        resp_err   <= err;
        resp_rdata <= (err || cur_write) ? 32'h0 : load_val;
      end
    end
  end

  // Storage has no reset; an aborted access never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[cur_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-array memory model,
// with directed cases for the documented load/store, alias, error and reset behaviour.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_f3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_mem [4*DEPTH];
  logic [31:0] obs;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_f3(req_f3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Byte-granular memory model: size from f3, little-endian assembly, sign extension by arithmetic.
  function automatic void modelAccess(input logic wr, input logic [31:0] a, input logic [2:0] f3,
                                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size, base;
    logic legal;
    logic [31:0] val;
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    base  = int'(a % (4 * DEPTH));
    er    = !legal || (base % size != 0);
    rd    = 32'h0;
    if (er) return;
    if (wr) begin
      for (int i = 0; i < size; i++) model_mem[base + i] = wd[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(model_mem[base + i]) << (8 * i));
      if (!f3[2] && size < 4 && model_mem[base + size - 1][7]) val = val | (32'hFFFFFFFF << (8 * size));
      rd = val;
    end
  endfunction

  task automatic driveGarbage();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_f3    = 3'($urandom);
    req_wdata = $urandom;
  endtask

  // One complete access: present, wait for the response, optionally stall, then retire.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [2:0] f3,
                               input logic [31:0] wd, input int hold, output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    modelAccess(wr, a, f3, wd, exp_rd, exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_f3 = f3; req_wdata = wd;
    resp_ready = 1'b0;
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      driveGarbage();
    end while (!resp_valid && n < 40);
    checkOutput("latency", 32'(n), 32'(WAITC + 1));
    checkOutput("resp_rdata", resp_rdata, exp_rd);
    checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
    got = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      driveGarbage();
      checkOutput("stall_valid", 32'(resp_valid), 32'd1);
      checkOutput("stall_rdata", resp_rdata, exp_rd);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("retire_valid", 32'(resp_valid), 32'd0);
    checkOutput("retire_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_f3 = 3'b000; req_wdata = 32'h0; resp_ready = 1'b0;
    #3;
    checkOutput("reset_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'h0);
    checkOutput("reset_err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_release_ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < DEPTH; w++) applyStimulus(1'b1, 32'(4 * w), 3'b010, $urandom, 0, obs);

    applyStimulus(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, obs);
    applyStimulus(1'b0, 32'h10, 3'b010, 32'h0, 0, obs);
    checkOutput("lw_deadbeef", obs, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h13, 3'b000, 32'h0, 0, obs);
    checkOutput("lb_13", obs, 32'hFFFFFFDE);
    applyStimulus(1'b0, 32'h13, 3'b100, 32'h0, 0, obs);
    checkOutput("lbu_13", obs, 32'h000000DE);
    applyStimulus(1'b0, 32'h12, 3'b001, 32'h0, 0, obs);
    checkOutput("lh_12", obs, 32'hFFFFDEAD);
    applyStimulus(1'b0, 32'h10, 3'b101, 32'h0, 0, obs);
    checkOutput("lhu_10", obs, 32'h0000BEEF);
    applyStimulus(1'b1, 32'h11, 3'b000, 32'h00000055, 0, obs);
    applyStimulus(1'b0, 32'h10, 3'b010, 32'h0, 0, obs);
    checkOutput("sb_merge", obs, 32'hDEAD55EF);
    applyStimulus(1'b1, 32'h110, 3'b010, 32'hA5A55A5A, 0, obs);
    applyStimulus(1'b0, 32'h10, 3'b010, 32'h0, 0, obs);
    checkOutput("alias_0x110", obs, 32'hA5A55A5A);
    applyStimulus(1'b0, 32'h12, 3'b010, 32'h0, 0, obs);
    checkOutput("lw_misaligned_rdata", obs, 32'h0);
    applyStimulus(1'b1, 32'h11, 3'b001, 32'hFFFF, 0, obs);
    applyStimulus(1'b0, 32'h10, 3'b010, 32'h0, 5, obs);
    checkOutput("err_no_write", obs, 32'hA5A55A5A);

    applyStimulus(1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 0, obs);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_f3 = 3'b010; req_wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("wait_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_release_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 32'h20, 3'b010, 32'h0, 0, obs);
    checkOutput("abort_prior_contents", obs, 32'hCAFEF00D);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_f3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (WAITC) @(negedge clk);
    checkOutput("resp_before_reset", 32'(resp_valid), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_in_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'($urandom), $urandom, 3'($urandom), $urandom, $urandom_range(0, 3), obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
